sram_arbiter: RTL and testbench

//   Shares the single external async SRAM between instruction fetch (IF, read-only)
//   and the memory stage (MEM, read/write). Arbitrates between the two, sequences
//   the multi-cycle SRAM read/write timing, and gives each requester a req/ready

---
 rtl/sram_arbiter_if.sv | 22 ++
 rtl/sram_arbiter.sv | 113 +++++++++++
 tb/tb_sram_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: IF/MEM requester handshake bundle for sram_arbiter
interface sram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output if_rdata, if_ready, mem_rdata, mem_ready
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between IF (read) and MEM (read/write).
// ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests; default is MEM > IF.
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_byte_en_n,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [31:0]       ram_data
);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        gnt_mem;
  logic        drive;
  logic [31:0] wdata;
  logic        pick_mem;
  logic        unused;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_mem;
  assign pick_mem = bus.mem_req & (~bus.if_req | ~last_mem);
`else
  assign pick_mem = bus.mem_req;
`endif
  assign ram_data = drive ? wdata : 'z;
  assign unused = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2], bus.mem_addr[1:0], bus.mem_addr[31:ADDR_W+2]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      gnt_mem       <= 1'b0;
      drive         <= 1'b0;
      wdata         <= '0;
      ram_ce_n      <= 1'b1;
      ram_oe_n      <= 1'b1;
      ram_we_n      <= 1'b1;
      ram_byte_en_n <= 4'hF;
      ram_addr      <= '0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem      <= 1'b0;
`endif
    end else begin
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      case (state)
        IDLE: if (bus.if_req | bus.mem_req) begin
          gnt_mem       <= pick_mem;
          ram_addr      <= pick_mem ? bus.mem_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
          ram_byte_en_n <= pick_mem ? ~bus.mem_be : 4'h0;
          ram_ce_n      <= 1'b0;
          wdata         <= bus.mem_wdata;
          cnt           <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_mem      <= pick_mem;
`endif
          if (pick_mem & bus.mem_we) begin
            state <= WR_SETUP;
            drive <= 1'b1;
          end else begin
            state    <= RD;
            ram_oe_n <= 1'b0;
          end
        end
        RD: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            if (gnt_mem) begin
              bus.mem_rdata <= ram_data;
              bus.mem_ready <= 1'b1;
            end else begin
              bus.if_rdata <= ram_data;
              bus.if_ready <= 1'b1;
            end
            ram_ce_n      <= 1'b1;
            ram_oe_n      <= 1'b1;
            ram_byte_en_n <= 4'hF;
            state         <= DONE;
          end
        end
        WR_SETUP: begin
          ram_we_n <= 1'b0;
          state    <= WR_PULSE;
        end
        WR_PULSE: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            ram_we_n <= 1'b1;
            state    <= WR_HOLD;
          end
        end
        WR_HOLD: begin
          drive         <= 1'b0;
          ram_ce_n      <= 1'b1;
          ram_byte_en_n <= 4'hF;
          bus.mem_ready <= 1'b1;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scoreboard bench for sram_arbiter against a transaction-level model
module tb_sram_arbiter;
  localparam int W = 2;
  typedef struct {logic [31:0] d; bit rd; int t;} exp_t;
  logic        clk, rst, load;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0]  ram_byte_en_n;
  logic [19:0] ram_addr;
  wire  [31:0] ram_data;
  logic [31:0] sram [0:63];
  logic [31:0] ref_mem [0:63];
  exp_t        if_q[$], mem_q[$];
  int          cyc = 0, n_pass = 0, n_total = 0, we_cnt = 0, oe_cnt = 0;
  bit          last_mem;
  sram_arbiter_if bus();
  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_byte_en_n(ram_byte_en_n), .ram_addr(ram_addr), .ram_data(ram_data)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0F0F;
  endfunction
  // async SRAM device: drives the bus while selected for read, writes enabled lanes while WE is low
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[5:0]] : 'z;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
    end else if (!ram_ce_n && !ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!ram_byte_en_n[b]) sram[ram_addr[5:0]][8*b +: 8] <= ram_data[8*b +: 8];
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask
  task automatic fail_now(string name);
    n_total++;
    $display("FAIL %s", name);
  endtask
  function automatic logic [31:0] mk_addr(int w, bit junk);
    logic [9:0] hi;
    logic [1:0] lo;
    hi = junk ? 10'($urandom) : 10'h0;
    lo = junk ? 2'($urandom) : 2'h0;
    return {hi, 14'h0, 6'(w), lo};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      we_cnt = 0;
      oe_cnt = 0;
    end else begin
      chk("oe_we_exclusive", {31'h0, ~ram_oe_n & ~ram_we_n}, 32'h0);
      if (!ram_ce_n) chk("ram_addr_upper", {12'h0, ram_addr[19:6], 6'h0}, 32'h0);
      if (!ram_we_n) we_cnt++;
      else if (we_cnt != 0) begin
        chk("we_pulse_len", 32'(we_cnt), 32'(W));
        we_cnt = 0;
      end
      if (!ram_oe_n) oe_cnt++;
      else if (oe_cnt != 0) begin
        chk("oe_pulse_len", 32'(oe_cnt), 32'(W));
        oe_cnt = 0;
      end
      if (bus.if_ready) begin
        if (if_q.size() == 0) fail_now("unexpected_if_ready");
        else begin
          e = if_q.pop_front();
          chk("if_rdata", bus.if_rdata, e.d);
          chk("if_ready_cycle", 32'(cyc), 32'(e.t));
        end
      end
      if (bus.mem_ready) begin
        if (mem_q.size() == 0) fail_now("unexpected_mem_ready");
        else begin
          e = mem_q.pop_front();
          if (e.rd) chk("mem_rdata", bus.mem_rdata, e.d);
          chk("mem_ready_cycle", 32'(cyc), 32'(e.t));
        end
      end
    end
  end
  task automatic wait_done();
    for (int n = 0; n < 60 && (bus.if_req || bus.mem_req); n++) begin
      @(posedge clk); #1;
      if (bus.if_ready) bus.if_req = 0;
      if (bus.mem_ready) bus.mem_req = 0;
    end
    if (bus.if_req || bus.mem_req) begin
      fail_now("handshake_timeout");
      bus.if_req = 0;
      bus.mem_req = 0;
    end
  endtask
  // model: serve requests in arbitration order, each accept one cycle after the previous ready
  task automatic txn(bit di, bit dm, bit we, int iw, int mw, logic [3:0] be, logic [31:0] wd, bit junk);
    int t;
    bit mf, m;
    @(posedge clk); #1;
    bus.if_req = di;
    bus.if_addr = mk_addr(iw, junk);
    bus.mem_req = dm;
    bus.mem_we = we;
    bus.mem_addr = mk_addr(mw, junk);
    bus.mem_be = be;
    bus.mem_wdata = wd;
    t = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    mf = dm && (!di || !last_mem);
`else
    mf = dm;
`endif
    for (int k = 0; k < 2; k++) begin
      m = (k == 0) ? mf : !mf;
      if (m ? dm : di) begin
        if (m) begin
          t += we ? W + 3 : W + 1;
          if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[mw][8*b +: 8] = wd[8*b +: 8];
            mem_q.push_back('{32'h0, 1'b0, t});
          end else mem_q.push_back('{ref_mem[mw], 1'b1, t});
        end else begin
          t += W + 1;
          if_q.push_back('{ref_mem[iw], 1'b1, t});
        end
        last_mem = m;
        t += 1;
      end
    end
    wait_done();
  endtask
  initial begin
    int n, kind;
    rst = 1;
    load = 1;
    bus.if_req = 0;
    bus.if_addr = 0;
    bus.mem_req = 0;
    bus.mem_we = 0;
    bus.mem_addr = 0;
    bus.mem_be = 0;
    bus.mem_wdata = 0;
    last_mem = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", {31'h0, ram_ce_n}, 32'h1);
    chk("rst_oe_n", {31'h0, ram_oe_n}, 32'h1);
    chk("rst_we_n", {31'h0, ram_we_n}, 32'h1);
    chk("rst_byte_en_n", {28'h0, ram_byte_en_n}, 32'hF);
    chk("rst_ram_addr", {12'h0, ram_addr}, 32'h0);
    chk("rst_ready", {30'h0, bus.if_ready, bus.mem_ready}, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    rst = 0;
    load = 0;
    txn(1, 0, 0, 4, 0, 4'hF, 32'h0, 0);
    txn(0, 1, 1, 0, 8, 4'b0011, 32'h0000_1234, 0);
    txn(1, 0, 0, 8, 0, 4'hF, 32'h0, 0);
    txn(1, 1, 0, 5, 16, 4'hF, 32'h0, 0);
    txn(1, 1, 0, 6, 17, 4'hF, 32'h0, 0);
    txn(0, 1, 1, 0, 9, 4'h0, 32'hFFFF_FFFF, 0);
    txn(0, 1, 0, 0, 9, 4'hF, 32'h0, 0);
    // reset during the write pulse; rewriting the stored word keeps the model valid
    @(posedge clk); #1;
    bus.mem_req = 1;
    bus.mem_we = 1;
    bus.mem_addr = mk_addr(12, 0);
    bus.mem_be = 4'hF;
    bus.mem_wdata = ref_mem[12];
    n = 0;
    while (ram_we_n && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (ram_we_n) fail_now("we_pulse_timeout");
    rst = 1;
    @(posedge clk); #1;
    chk("abort_we_n", {31'h0, ram_we_n}, 32'h1);
    chk("abort_ce_n", {31'h0, ram_ce_n}, 32'h1);
    chk("abort_oe_n", {31'h0, ram_oe_n}, 32'h1);
    rst = 0;
    bus.mem_req = 0;
    last_mem = 0;
    repeat (8) @(posedge clk);
    txn(0, 1, 0, 0, 12, 4'hF, 32'h0, 0);
    // back-to-back MEM reads with req held high
    @(posedge clk); #1;
    bus.mem_req = 1;
    bus.mem_we = 0;
    bus.mem_addr = 32'h0;
    bus.mem_be = 4'hF;
    mem_q.push_back('{ref_mem[0], 1'b1, cyc + W + 1});
    mem_q.push_back('{ref_mem[1], 1'b1, cyc + 2 * W + 3});
    last_mem = 1;
    n = 0;
    for (int k = 0; k < 40 && bus.mem_req; k++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        n++;
        if (n == 1) bus.mem_addr = 32'h4;
        else bus.mem_req = 0;
      end
    end
    if (bus.mem_req) begin
      fail_now("b2b_timeout");
      bus.mem_req = 0;
    end
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, 1'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
          4'($urandom), $urandom, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (6) @(posedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
